// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded burst locking in front of the single-ported data memory.
// Misaligned or illegal accesses are granted but never reach memory. They complete with err=1.
module dmem_arbiter #(
  parameter int PROG_VALUE = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [2:0]            funct3_0,
  input  logic [2:0]            funct3_1,
  input  logic [PROG_VALUE-1:0] addr0,
  input  logic [PROG_VALUE-1:0] addr1,
  input  logic [PROG_VALUE-1:0] wdata0,
  input  logic [PROG_VALUE-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [PROG_VALUE-1:0] rdata0,
  output logic [PROG_VALUE-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [PROG_VALUE-1:0] addr,
  output logic [PROG_VALUE-1:0] dataW,
  output logic                  MemRW,
  output logic [2:0]            funct3,
  input  logic [PROG_VALUE-1:0] dataR,
  output logic [1:0]            state_dbg
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);
  localparam logic [BW-1:0] BONE = BW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                state;
  logic                  last;
  logic [BW-1:0]         bcnt;
  logic                  g0, g1, force_drop;
  logic                  mis0, mis1;
  logic                  rv0_q, rv1_q, err0_q, err1_q;
  logic [PROG_VALUE-1:0] rdata0_q, rdata1_q;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = a[0];
      3'b010:         misaligned = (a != 2'b00);
      default:        misaligned = 1'b1;
    endcase
  endfunction

  assign mis0 = misaligned(funct3_0, addr0[1:0]);
  assign mis1 = misaligned(funct3_1, addr1[1:0]);

  // Handshake: a port holds req and its payload stable until gnt is high in the same cycle.
  // Each grant is one memory access. Exactly one rvalid pulse follows on the next cycle.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    force_drop = 1'b0;
    unique case (state)
      OWN0: begin
        if (req0) begin
          if (bcnt == BMAX && req1) begin
            g1 = 1'b1;
            force_drop = 1'b1;
          end else begin
            g0 = 1'b1;
          end
        end else begin
          g1 = req1;
        end
      end
      OWN1: begin
        if (req1) begin
          if (bcnt == BMAX && req0) begin
            g0 = 1'b1;
            force_drop = 1'b1;
          end else begin
            g1 = 1'b1;
          end
        end else begin
          g0 = req0;
        end
      end
      default: begin
        if (req0 && req1) begin
          g0 = last;
          g1 = ~last;
        end else begin
          g0 = req0;
          g1 = req1;
        end
      end
    endcase
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
      force_drop = 1'b0;
    end
  end

  assign gnt0   = g0;
  assign gnt1   = g1;
  assign addr   = g1 ? addr1 : addr0;
  assign dataW  = g1 ? wdata1 : wdata0;
  assign funct3 = g1 ? funct3_1 : funct3_0;
  assign MemRW  = (g0 & we0 & ~mis0) | (g1 & we1 & ~mis1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      bcnt     <= '0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (g0 || g1) last <= g1;
      if (force_drop) begin
        state <= IDLE;
        bcnt  <= '0;
      end else if (g0) begin
        if (lock0) begin
          state <= OWN0;
          if (state != OWN0)   bcnt <= BONE;
          else if (bcnt != BMAX) bcnt <= bcnt + BONE;
        end else begin
          state <= IDLE;
          bcnt  <= '0;
        end
      end else if (g1) begin
        if (lock1) begin
          state <= OWN1;
          if (state != OWN1)   bcnt <= BONE;
          else if (bcnt != BMAX) bcnt <= bcnt + BONE;
        end else begin
          state <= IDLE;
          bcnt  <= '0;
        end
      end else begin
        state <= IDLE;
        bcnt  <= '0;
      end
      rv0_q    <= g0;
      rv1_q    <= g1;
      err0_q   <= g0 & mis0;
      err1_q   <= g1 & mis1;
      rdata0_q <= (g0 && !we0 && !mis0) ? dataR : '0;
      rdata1_q <= (g1 && !we1 && !mis1) ? dataR : '0;
    end
  end

  // A completion whose cycle coincides with reset is discarded.
  assign rvalid0   = rv0_q & ~rst;
  assign rvalid1   = rv1_q & ~rst;
  assign err0      = err0_q & ~rst;
  assign err1      = err1_q & ~rst;
  assign rdata0    = rst ? '0 : rdata0_q;
  assign rdata1    = rst ? '0 : rdata1_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model behind the arbiter.
// Inputs change just after negedge. Outputs are sampled 1 time unit later.
module tb_dmem_arbiter;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_BAD = 3'b011;

  logic        clk, rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [2:0]  funct3_0, funct3_1, funct3;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, MemRW;
  logic [31:0] rdata0, rdata1, addr, dataW, dataR;
  logic [1:0]  state_dbg;
  logic [7:0]  mem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.PROG_VALUE(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .funct3_0(funct3_0), .funct3_1(funct3_1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1), .addr(addr), .dataW(dataW), .MemRW(MemRW),
    .funct3(funct3), .dataR(dataR), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Memory model: combinational read, store committed on posedge
  always_comb begin
    logic [7:0] a;
    a = addr[7:0];
    case (funct3)
      3'b000:  dataR = {{24{mem[a][7]}}, mem[a]};
      3'b100:  dataR = {24'h0, mem[a]};
      3'b001:  dataR = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
      3'b101:  dataR = {16'h0, mem[a+8'd1], mem[a]};
      default: dataR = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (MemRW) begin
      mem[addr[7:0]] <= dataW[7:0];
      if (funct3[1:0] != 2'b00) mem[addr[7:0]+8'd1] <= dataW[15:8];
      if (funct3[1:0] == 2'b10) begin
        mem[addr[7:0]+8'd2] <= dataW[23:16];
        mem[addr[7:0]+8'd3] <= dataW[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic set0(input logic r, input logic w, input logic l, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d);
    req0 = r; we0 = w; lock0 = l; funct3_0 = f; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic l, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d);
    req1 = r; we1 = w; lock1 = l; funct3_1 = f; addr1 = a; wdata1 = d;
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, 1'b0, F_W, 32'h0, 32'h0);
    set1(1'b0, 1'b0, 1'b0, F_W, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset: a request during reset is not granted
    rst = 1'b1;
    idle();
    set0(1'b1, 1'b1, 1'b0, F_W, 32'h10, 32'hDEADBEEF);
    @(negedge clk); #1;
    check("rst_gnt0", {31'h0, gnt0}, 32'h0);
    check("rst_memrw", {31'h0, MemRW}, 32'h0);
    @(negedge clk); #1;
    check("rst_rvalid0", {31'h0, rvalid0}, 32'h0);
    check("rst_err0", {31'h0, err0}, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_state", {30'h0, state_dbg}, 32'h0);

    // SW then LW through port 0
    rst = 1'b0;
    #1;
    check("sw_gnt0", {31'h0, gnt0}, 32'h1);
    check("sw_memrw", {31'h0, MemRW}, 32'h1);
    check("sw_addr", addr, 32'h10);
    check("sw_dataw", dataW, 32'hDEADBEEF);
    @(negedge clk);
    set0(1'b1, 1'b0, 1'b0, F_W, 32'h10, 32'h0);
    #1;
    check("sw_rvalid0", {31'h0, rvalid0}, 32'h1);
    check("sw_rdata0", rdata0, 32'h0);
    check("sw_err0", {31'h0, err0}, 32'h0);
    check("lw_gnt0", {31'h0, gnt0}, 32'h1);
    check("lw_memrw", {31'h0, MemRW}, 32'h0);
    @(negedge clk);
    idle();
    #1;
    check("lw_rvalid0", {31'h0, rvalid0}, 32'h1);
    check("lw_rdata0", rdata0, 32'hDEADBEEF);
    @(negedge clk); #1;
    check("lw_rvalid0_done", {31'h0, rvalid0}, 32'h0);

    // Round robin from reset, no locks
    do_reset();
    set0(1'b1, 1'b0, 1'b0, F_W, 32'h10, 32'h0);
    set1(1'b1, 1'b0, 1'b0, F_W, 32'h10, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_gnt0_%0d", k), {31'h0, gnt0}, {31'h0, (k % 2 == 0)});
      check($sformatf("rr_gnt1_%0d", k), {31'h0, gnt1}, {31'h0, (k % 2 == 1)});
      if (k > 0) begin
        check($sformatf("rr_rvalid0_%0d", k), {31'h0, rvalid0}, {31'h0, ((k - 1) % 2 == 0)});
        check($sformatf("rr_rvalid1_%0d", k), {31'h0, rvalid1}, {31'h0, ((k - 1) % 2 == 1)});
        check($sformatf("rr_rdata_%0d", k), rdata0 | rdata1, 32'hDEADBEEF);
      end
      @(negedge clk);
    end

    // Locked burst by port 1, yield after 8 grants, then regain
    do_reset();
    set1(1'b1, 1'b0, 1'b1, F_W, 32'h10, 32'h0);
    #1;
    check("burst_gnt1_0", {31'h0, gnt1}, 32'h1);
    @(negedge clk);
    set0(1'b1, 1'b0, 1'b0, F_W, 32'h10, 32'h0);
    for (int i = 1; i < 8; i++) begin
      #1;
      check($sformatf("burst_gnt1_%0d", i), {31'h0, gnt1}, 32'h1);
      check($sformatf("burst_gnt0_%0d", i), {31'h0, gnt0}, 32'h0);
      @(negedge clk);
    end
    #1;
    check("burst_yield_gnt0", {31'h0, gnt0}, 32'h1);
    check("burst_yield_gnt1", {31'h0, gnt1}, 32'h0);
    @(negedge clk); #1;
    check("burst_regain_gnt1", {31'h0, gnt1}, 32'h1);
    check("burst_regain_gnt0", {31'h0, gnt0}, 32'h0);
    @(negedge clk); #1;
    check("burst_state_own1", {30'h0, state_dbg}, 32'h2);

    // Reset while port 1 owns the memory
    rst = 1'b1;
    #1;
    check("rstb_gnt1", {31'h0, gnt1}, 32'h0);
    check("rstb_gnt0", {31'h0, gnt0}, 32'h0);
    check("rstb_rvalid1", {31'h0, rvalid1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstb_state_idle", {30'h0, state_dbg}, 32'h0);
    check("rstb_no_rvalid1", {31'h0, rvalid1}, 32'h0);
    check("rstb_no_rvalid0", {31'h0, rvalid0}, 32'h0);
    check("rstb_first_gnt0", {31'h0, gnt0}, 32'h1);
    check("rstb_first_gnt1", {31'h0, gnt1}, 32'h0);
    @(negedge clk);
    idle();
    @(negedge clk);

    // Misaligned and illegal accesses
    set0(1'b1, 1'b0, 1'b0, F_H, 32'h13, 32'h0);
    #1;
    check("lh13_gnt0", {31'h0, gnt0}, 32'h1);
    check("lh13_memrw", {31'h0, MemRW}, 32'h0);
    @(negedge clk);
    set0(1'b1, 1'b1, 1'b0, F_W, 32'h12, 32'h11223344);
    #1;
    check("lh13_rvalid0", {31'h0, rvalid0}, 32'h1);
    check("lh13_err0", {31'h0, err0}, 32'h1);
    check("lh13_rdata0", rdata0, 32'h0);
    check("sw12_gnt0", {31'h0, gnt0}, 32'h1);
    check("sw12_memrw", {31'h0, MemRW}, 32'h0);
    @(negedge clk);
    set0(1'b1, 1'b0, 1'b0, F_BAD, 32'h10, 32'h0);
    #1;
    check("sw12_err0", {31'h0, err0}, 32'h1);
    check("sw12_rdata0", rdata0, 32'h0);
    check("bad_memrw", {31'h0, MemRW}, 32'h0);
    @(negedge clk);
    set0(1'b1, 1'b0, 1'b0, F_W, 32'h10, 32'h0);
    #1;
    check("bad_err0", {31'h0, err0}, 32'h1);
    check("bad_rdata0", rdata0, 32'h0);
    @(negedge clk);
    set0(1'b0, 1'b0, 1'b0, F_W, 32'h44, 32'h0);
    #1;
    check("reload_rdata0", rdata0, 32'hDEADBEEF);
    check("reload_err0", {31'h0, err0}, 32'h0);
    check("nogrant_addr", addr, 32'h44);
    check("nogrant_gnt0", {31'h0, gnt0}, 32'h0);
    check("nogrant_memrw", {31'h0, MemRW}, 32'h0);
    @(negedge clk);

    // SB via port 1, then LBU and LB via port 0
    set1(1'b1, 1'b1, 1'b0, F_B, 32'h21, 32'h000000AB);
    #1;
    check("sb_gnt1", {31'h0, gnt1}, 32'h1);
    check("sb_memrw", {31'h0, MemRW}, 32'h1);
    check("sb_addr", addr, 32'h21);
    check("sb_funct3", {29'h0, funct3}, 32'h0);
    @(negedge clk);
    set1(1'b0, 1'b0, 1'b0, F_W, 32'h0, 32'h0);
    set0(1'b1, 1'b0, 1'b0, F_BU, 32'h21, 32'h0);
    #1;
    check("sb_rvalid1", {31'h0, rvalid1}, 32'h1);
    check("sb_err1", {31'h0, err1}, 32'h0);
    check("sb_rdata1", rdata1, 32'h0);
    @(negedge clk);
    set0(1'b1, 1'b0, 1'b0, F_B, 32'h21, 32'h0);
    #1;
    check("lbu_rdata0", rdata0, 32'h000000AB);
    @(negedge clk);
    idle();
    #1;
    check("lb_rdata0", rdata0, 32'hFFFFFFAB);
    check("lb_rvalid0", {31'h0, rvalid0}, 32'h1);
    @(negedge clk); #1;
    check("end_rvalid0", {31'h0, rvalid0}, 32'h0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
